// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch stage, the instruction cache
// port and the decode handshake: fetch FSM state encoding, cache-port widths
// and the instruction size in bytes.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        WAIT = 3'd3,
        HALT = 3'd4
    } fetch_state_t;

    // Cache request (address) and response (data) widths.
    localparam int IC_ADDR_WIDTH = 32;
    localparam int IC_DATA_WIDTH = 32;

    // Bytes per instruction word at the default data width.
    localparam int INSTR_BYTES = IC_DATA_WIDTH / 8;

    function automatic int instr_bytes(input int data_bitwidth);
        return data_bitwidth / 8;
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous first-word-fall-through FIFO with flush and occupancy count.
// The head entry is visible on head_data whenever empty is low; head_data
// reads as zero while empty so the consumer never sees stale storage.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   flush      empty the FIFO on the next edge (wins over push/pop)
//   push       write push_data (ignored when full unless popping)
//   push_data  entry to write
//   pop        consume the head entry (ignored when empty)
//   head_data  current head entry
//   empty      no entries held
//   count      number of entries held, 0 .. 2^DEPTH_BITWIDTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH          = 64,
    parameter int DEPTH_BITWIDTH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head_data,
    output logic                      empty,
    output logic [DEPTH_BITWIDTH:0]   count
);

    localparam int DEPTH = 1 << DEPTH_BITWIDTH;
    localparam int CW    = DEPTH_BITWIDTH + 1;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [DEPTH_BITWIDTH-1:0] wr_ptr;
    logic [DEPTH_BITWIDTH-1:0] rd_ptr;
    logic                      full;
    logic                      do_push;
    logic                      do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full FIFO can still accept a write when the head leaves this cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage between the instruction cache and decode. Owns the
// program counter, issues one word request at a time on the cache
// enable/busy/data_ready port, and buffers returned words tagged with their
// PC in a small FWFT FIFO offered to decode with valid/ready. A redirect loads
// a new PC, flushes the FIFO and drops any response still in flight.
//
// Build option FETCH_ALIGN_CHECK_EN:
//   defined   - a misaligned redirect raises fault/fault_pc and parks the
//               unit in HALT until an aligned redirect arrives.
//   undefined - redirect targets are forced to instruction alignment and
//               fault/fault_pc are tied to zero.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   redirect        load redirect_pc as the next fetch address, flush FIFO
//   redirect_pc     redirect target
//   out_valid       FIFO head valid
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction
//   out_pc          head instruction address
//   fault           misaligned redirect pending
//   fault_pc        offending redirect target
//   ic_enable       one-cycle registered cache request pulse
//   ic_address      registered request address
//   ic_data         cache read data (held until the next request)
//   ic_data_ready   cache data valid (hit)
//   ic_busy         cache servicing a miss
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request outstanding; issue when FIFO has room and cache is free
// REQ   | ic_enable high this cycle only
// RESP  | first response cycle: hit captures, busy goes to WAIT, else reissue
// WAIT  | miss in progress; capture on the cycle ic_busy drops
// HALT  | misaligned redirect seen; no requests until an aligned redirect
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                          ADDRESS_BITWIDTH    = IC_ADDR_WIDTH,
    parameter int                          DATA_BITWIDTH       = IC_DATA_WIDTH,
    parameter logic [ADDRESS_BITWIDTH-1:0] RESET_PC            = '0,
    parameter int                          FIFO_DEPTH_BITWIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect,
    input  logic [ADDRESS_BITWIDTH-1:0]  redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_BITWIDTH-1:0]     out_instr,
    output logic [ADDRESS_BITWIDTH-1:0]  out_pc,
    output logic                         fault,
    output logic [ADDRESS_BITWIDTH-1:0]  fault_pc,
    output logic                         ic_enable,
    output logic [ADDRESS_BITWIDTH-1:0]  ic_address,
    input  logic [DATA_BITWIDTH-1:0]     ic_data,
    input  logic                         ic_data_ready,
    input  logic                         ic_busy
);

    localparam int BYTES_PER_INSTR = instr_bytes(DATA_BITWIDTH);
    localparam int FIFO_DEPTH      = 1 << FIFO_DEPTH_BITWIDTH;
    localparam int CW              = FIFO_DEPTH_BITWIDTH + 1;
    localparam int ENTRY_W         = ADDRESS_BITWIDTH + DATA_BITWIDTH;

    localparam logic [ADDRESS_BITWIDTH-1:0] PC_STEP     = ADDRESS_BITWIDTH'(BYTES_PER_INSTR);
    localparam logic [ADDRESS_BITWIDTH-1:0] OFFSET_MASK = ADDRESS_BITWIDTH'(BYTES_PER_INSTR - 1);
    localparam logic [CW-1:0]               DEPTH_C     = CW'(FIFO_DEPTH);

    fetch_state_t                 state;
    logic [ADDRESS_BITWIDTH-1:0]  fetch_pc;
    logic                         discard;

    logic                         capture;
    logic                         push;
    logic                         pop;
    logic                         fifo_empty;
    logic [CW-1:0]                fifo_count;
    logic [CW-1:0]                count_after;
    logic                         issue_idle;
    logic                         issue_after;
    logic                         inflight_cont;
    logic [ADDRESS_BITWIDTH-1:0]  pc_inc;
    logic [ADDRESS_BITWIDTH-1:0]  next_pc_after;
    logic [ADDRESS_BITWIDTH-1:0]  target_pc;
    logic                         misaligned;
    logic [ENTRY_W-1:0]           fifo_head;

    // Response arrives either as a hit in RESP or when a miss completes.
    assign capture = ((state == RESP) && !ic_busy && ic_data_ready) ||
                     ((state == WAIT) && !ic_busy);

    // A redirect in the capture cycle drops the word being returned.
    assign push = capture && !discard && !redirect;
    assign pop  = out_valid && out_ready;

    // Occupancy after this edge; issuing against it guarantees the next
    // capture always finds a free slot.
    assign count_after = fifo_count + CW'(push) - CW'(pop);

    assign issue_idle  = (fifo_count  < DEPTH_C) && !ic_busy && !fault;
    assign issue_after = (count_after < DEPTH_C) && !ic_busy && !fault;

    assign pc_inc        = fetch_pc + PC_STEP;
    assign next_pc_after = discard ? fetch_pc : pc_inc;

    // True when a request is still outstanding past this edge, so its
    // response must be dropped if a redirect lands now.
    assign inflight_cont = (state == REQ) ||
                           (((state == RESP) || (state == WAIT)) && ic_busy);

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_pc  = redirect_pc;
    assign misaligned = (redirect_pc & OFFSET_MASK) != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault    <= 1'b0;
            fault_pc <= '0;
        end else if (redirect) begin
            fault <= misaligned;
            if (misaligned) begin
                fault_pc <= redirect_pc;
            end
        end
    end
`else
    assign target_pc  = redirect_pc & ~OFFSET_MASK;
    assign misaligned = 1'b0;
    assign fault      = 1'b0;
    assign fault_pc   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            discard    <= 1'b0;
            ic_enable  <= 1'b0;
            ic_address <= RESET_PC;
        end else begin
            ic_enable <= 1'b0;

            case (state)
                IDLE: begin
                    if (issue_idle) begin
                        ic_enable  <= 1'b1;
                        ic_address <= fetch_pc;
                        state      <= REQ;
                    end else if (fault) begin
                        state <= HALT;
                    end
                end
                REQ: begin
                    state <= RESP;
                end
                RESP: begin
                    if (ic_busy) begin
                        state <= WAIT;
                    end else if (!ic_data_ready) begin
                        // Nothing came back: the request is gone, so the
                        // reissue is a fresh fetch that must be kept.
                        discard <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: ;
            endcase

            if (capture) begin
                if (!discard) begin
                    fetch_pc <= pc_inc;
                end
                discard <= 1'b0;
                if (issue_after) begin
                    ic_enable  <= 1'b1;
                    ic_address <= next_pc_after;
                    state      <= REQ;
                end else begin
                    state <= fault ? HALT : IDLE;
                end
            end

            // Redirect overrides everything above. An outstanding request
            // keeps the FSM on its response path with discard set.
            if (redirect) begin
                fetch_pc  <= target_pc;
                ic_enable <= 1'b0;
                discard   <= inflight_cont;
                if (!inflight_cont) begin
                    state <= misaligned ? HALT : IDLE;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH          (ENTRY_W),
        .DEPTH_BITWIDTH (FIFO_DEPTH_BITWIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({fetch_pc, ic_data}),
        .pop       (pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid           = !fifo_empty;
    assign {out_pc, out_instr} = fifo_head;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int MISS_CYCLES = 10;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic        ic_enable;
    logic [31:0] ic_address;
    logic [31:0] ic_data;
    logic        ic_data_ready;
    logic        ic_busy;

    logic        miss_en;
    logic [31:0] miss_addr;
    logic [3:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fault         (fault),
        .fault_pc      (fault_pc),
        .ic_enable     (ic_enable),
        .ic_address    (ic_address),
        .ic_data       (ic_data),
        .ic_data_ready (ic_data_ready),
        .ic_busy       (ic_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents seen through the cache.
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Cache responder: hit returns data_ready the cycle after ic_enable;
    // a request to miss_addr (while miss_en) holds ic_busy for MISS_CYCLES.
    always @(posedge clk) begin
        if (rst) begin
            ic_busy       <= 1'b0;
            ic_data_ready <= 1'b0;
            ic_data       <= '0;
            busy_cnt      <= '0;
        end else if (ic_enable) begin
            ic_data <= word(ic_address);
            if (miss_en && ic_address == miss_addr) begin
                ic_busy       <= 1'b1;
                ic_data_ready <= 1'b0;
                busy_cnt      <= 4'(MISS_CYCLES);
            end else begin
                ic_data_ready <= 1'b1;
            end
        end else begin
            ic_data_ready <= 1'b0;
            if (ic_busy) begin
                if (busy_cnt == 4'd1) ic_busy <= 1'b0;
                busy_cnt <= busy_cnt - 4'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input int bound, output bit ok, output int ov);
        ok = 1'b0;
        ov = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ic_enable === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (out_valid === 1'b1) ov++;
        end
    endtask

    task automatic wait_addr(input logic [31:0] a, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ic_enable === 1'b1 && ic_address === a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic window(input int n, output int en, output int ov);
        en = 0;
        ov = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ic_enable !== 1'b0) en++;
            if (out_valid !== 1'b0) ov++;
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          en_cnt;
        int          ov_cnt;
        logic [31:0] base;

        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;
        miss_en     = 1'b0;
        miss_addr   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ic_enable", ic_enable, 0);
        check("rst_ic_address", ic_address, 32'h0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_fault", fault, 0);
        check("rst_fault_pc", fault_pc, 32'h0);
        rst = 1'b0;

        // Hits, decode ready: enable every 2nd cycle, sequential PCs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hit_en_high", ic_enable, 1);
            check("hit_address", ic_address, 32'(i * 4));
            if (i > 0) begin
                check("hit_out_valid", out_valid, 1);
                check("hit_out_pc", out_pc, 32'((i - 1) * 4));
                check("hit_out_instr", out_instr, word(32'((i - 1) * 4)));
            end
            @(negedge clk);
            check("hit_en_low", ic_enable, 0);
        end

        // Miss at 0x20, busy for 10 cycles
        miss_addr = 32'h20;
        miss_en   = 1'b1;
        wait_addr(32'h20, 20, ok);
        check("miss_req_seen", ok, 1);
        window(11, en_cnt, ov_cnt);
        miss_en = 1'b0;
        check("miss_no_enable_while_busy", en_cnt, 0);
        check("miss_no_valid_while_busy", ov_cnt, 0);
        @(negedge clk);
        check("miss_out_valid", out_valid, 1);
        check("miss_out_pc", out_pc, 32'h20);
        check("miss_out_instr", out_instr, word(32'h20));
        check("miss_next_en", ic_enable, 1);
        check("miss_next_address", ic_address, 32'h24);

        // Decode stalls: two entries buffered, issue stops
        out_ready = 1'b0;
        window(8, en_cnt, ov_cnt);
        check("stall_no_enable", en_cnt, 0);
        check("stall_head_pc", out_pc, 32'h20);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_second_valid", out_valid, 1);
        check("drain_second_pc", out_pc, 32'h24);
        check("drain_second_instr", out_instr, word(32'h24));
        @(negedge clk);
        check("drain_empty", out_valid, 0);
        check("drain_resume_en", ic_enable, 1);
        check("drain_resume_address", ic_address, 32'h28);

        // Redirect to 0x100 during the WAIT of a miss at 0x40
        miss_addr = 32'h40;
        miss_en   = 1'b1;
        wait_addr(32'h40, 20, ok);
        check("redir_miss_req_seen", ok, 1);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("redir_pre_valid", out_valid, 1);
        check("redir_pre_pc", out_pc, 32'h3C);
        do_redirect(32'h100);
        check("redir_fifo_flushed", out_valid, 0);
        out_ready = 1'b1;
        miss_en   = 1'b0;
        wait_en(30, ok, ov_cnt);
        check("redir_en_seen", ok, 1);
        check("redir_address", ic_address, 32'h100);
        check("redir_0x40_dropped", ov_cnt, 0);
        repeat (2) @(negedge clk);
        check("redir_out_valid", out_valid, 1);
        check("redir_out_pc", out_pc, 32'h100);
        check("redir_out_instr", out_instr, word(32'h100));
        check("redir_next_address", ic_address, 32'h104);

        // PC wrap from 0xFFFFFFFC; redirect lands while 0x104 is in REQ
        do_redirect(32'hFFFF_FFFC);
        wait_en(10, ok, ov_cnt);
        check("wrap_en_seen", ok, 1);
        check("wrap_address", ic_address, 32'hFFFF_FFFC);
        wait_en(10, ok, ov_cnt);
        check("wrap_next_en_seen", ok, 1);
        check("wrap_next_address", ic_address, 32'h0);
        check("wrap_0x104_dropped", ov_cnt, 0);
        check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap_out_instr", out_instr, word(32'hFFFF_FFFC));

        // Misaligned redirect to 0x102
        do_redirect(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
        check("align_fault", fault, 1);
        check("align_fault_pc", fault_pc, 32'h102);
        window(10, en_cnt, ov_cnt);
        check("align_halt_no_enable", en_cnt, 0);
        check("align_halt_no_valid", out_valid, 0);
        check("align_fault_held", fault, 1);
        do_redirect(32'h200);
        check("align_fault_cleared", fault, 0);
        wait_en(10, ok, ov_cnt);
        check("align_resume_en", ok, 1);
        check("align_resume_address", ic_address, 32'h200);
        base = 32'h200;
`else
        check("mask_fault_zero", fault, 0);
        check("mask_fault_pc_zero", fault_pc, 32'h0);
        wait_en(10, ok, ov_cnt);
        check("mask_en_seen", ok, 1);
        check("mask_address", ic_address, 32'h100);
        base = 32'h100;
`endif

        // Reset in the middle of a miss
        miss_addr = base + 32'h8;
        miss_en   = 1'b1;
        wait_addr(base + 32'h8, 20, ok);
        check("rstmiss_req_seen", ok, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmiss_ic_enable", ic_enable, 0);
        check("rstmiss_ic_address", ic_address, 32'h0);
        check("rstmiss_out_valid", out_valid, 0);
        rst     = 1'b0;
        miss_en = 1'b0;
        @(negedge clk);
        check("rstmiss_first_en", ic_enable, 1);
        check("rstmiss_first_address", ic_address, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly downstream of the instruction cache and upstream of decode. Owns the program counter and issues one word request at a time to the cache using the cache's enable/busy/data_ready protocol. Buffers returned instructions, tagged with their PC, in a small FIFO with a valid/ready handshake to decode. Handles redirects (branches, jumps, traps) by flushing the FIFO and discarding any in-flight response.

## Interface
- ADDRESS_BITWIDTH, 32, byte address width.
- DATA_BITWIDTH, 32, instruction width; instruction bytes INSTR_BYTES = DATA_BITWIDTH/8.
- RESET_PC, 0, first fetch address after reset; must be INSTR_BYTES aligned.
- FIFO_DEPTH_BITWIDTH, 1, FIFO holds 2^N entries.

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- redirect  in  1  load new PC, flush FIFO
- redirect_pc  in  ADDRESS_BITWIDTH  redirect target
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_instr  out  DATA_BITWIDTH  head instruction
- out_pc  out  ADDRESS_BITWIDTH  head instruction address
- fault  out  1  misaligned redirect pending
- fault_pc  out  ADDRESS_BITWIDTH  offending target
- ic_enable  out  1  cache request, registered, one-cycle pulse
- ic_address  out  ADDRESS_BITWIDTH  request address
- ic_data  in  DATA_BITWIDTH  cache data
- ic_data_ready  in  1  cache data valid
- ic_busy  in  1  cache servicing miss

## Operation
- States: IDLE, REQ, RESP, WAIT, HALT.
- IDLE: if fifo_count < 2^N, !ic_busy, and no fault, register ic_enable=1 and ic_address=fetch_pc, then go to REQ.
- REQ: ic_enable=1 for this cycle only. Go to RESP.
- RESP: if ic_busy, go to WAIT (miss). Else if ic_data_ready, capture. Else reissue the same PC via IDLE.
- WAIT: stay while ic_busy. On ic_busy=0, capture (cache data holds the requested word until the next request).
- Capture: unless discard is set, push {fetch_pc, ic_data} and set fetch_pc += INSTR_BYTES (wraps modulo 2^ADDRESS_BITWIDTH). Clear discard.
- After capture: if issue conditions hold, go directly to REQ with enable registered. Otherwise go to IDLE.
- At most one request is in flight. Issue requires fifo_count < 2^N, so the push can never overflow.
- FIFO is first-word-fall-through: out_valid = !empty. A pop occurs on out_valid && out_ready. Simultaneous push and pop is allowed; count is unchanged.
- redirect (highest priority):
  - FIFO is emptied next cycle; a pop in the same cycle counts as consumed.
  - fetch_pc <= redirect_pc.
  - If the state is REQ, RESP or WAIT, discard is set and the response completes normally but is dropped.
  - A redirect during a discarded fetch overwrites fetch_pc and keeps discard set.
- A push and a redirect in the same cycle: the redirect wins and the pushed entry is dropped.

## Timing
- Reset values: ic_enable=0, ic_address=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0, state=IDLE, fetch_pc=RESET_PC, FIFO empty, discard=0.
- First ic_enable is high in the 2nd cycle after rst deasserts.
- Hit: ic_enable high in cycle N, capture at end of N+1, out_valid in N+2.
- Sustained hit rate with decode always ready: one instruction every 2 cycles.
- Miss: capture at the edge after ic_busy is sampled low; out_valid in the following cycle.
- rst mid-miss: the fetch unit returns to reset state immediately. The cache is reset by the same rst.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc % INSTR_BYTES != 0 sets fault=1 and fault_pc=redirect_pc.
  - The FIFO is flushed and the state goes to HALT once any in-flight fetch drains (discarded).
  - No issues occur in HALT.
  - A later aligned redirect clears fault and resumes from IDLE.
- FETCH_ALIGN_CHECK_EN undefined: the low log2(INSTR_BYTES) bits of redirect_pc are forced to 0; fault and fault_pc are constant 0.

## Structure
- Shared package/include holds the state encodings, INSTR_BYTES, and the cache-port request/response width constants shared with the cache and decode.
- One sub-module, fetch_fifo: parameterised sync FIFO with flush, count output, first-word-fall-through.

## Test plan
- Reset, cache always hits, decode always ready:
  - ic_address sequence 0x0, 0x4, 0x8…
  - out_pc/out_instr match memory.
  - ic_enable on every 2nd cycle.
- Miss at 0x20, ic_busy held high 10 cycles:
  - no new ic_enable while busy.
  - out_pc=0x20 valid one cycle after capture.
- out_ready=0:
  - exactly 2 entries are buffered and issue stops.
  - After releasing out_ready, entries drain in order with no loss or duplication.
- redirect to 0x100 during WAIT of a miss at 0x40:
  - the 0x40 word is never emitted.
  - the next ic_address is 0x100.
  - the FIFO is empty the cycle after the redirect.
- fetch_pc=0xFFFFFFFC with a hit: the next ic_address is 0x00000000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102:
  - fault=1, fault_pc=0x102, no ic_enable.
  - A redirect to 0x200 clears fault and fetches 0x200.
